// File: rtl/priority_scan_pkg.sv
// Shared types and helpers for the priority scan encoder: FSM state, the
// index reported on an all-zero vector, and a single-bit-set test.
package priority_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index driven on out_index for an all-zero ("none") beat.
    localparam int NONE_INDEX = 0;

    // Widest legal request vector; narrower vectors are zero-extended.
    localparam int MAX_WIDTH = 256;

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [MAX_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational find-first-set over a WIDTH-bit vector, from either end.
module prio_find #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     found
);

    localparam int IDX_W = $clog2(WIDTH);

    // Last assignment wins, so the scan direction picks which end has priority.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/priority_scan_encoder.sv
// Captures a request vector and streams the index of every set bit in
// priority order, one beat per output handshake; all-zero gives one "none" beat.
module priority_scan_encoder
    import priority_scan_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] out_index,
    output logic                     out_none,
    output logic                     out_last,
    output state_t                   dbg_state
);

    localparam int IDX_W = $clog2(WIDTH);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Producers must not withdraw valid before the transfer; in_ready may
    // depend combinationally on out_ready (last-beat overlap), nothing else.

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  residual_q, residual_d;
    logic              none_q, none_d;

    logic [IDX_W-1:0]  find_idx;
    logic              find_found;
    logic [WIDTH-1:0]  bit_mask;
    logic [MAX_WIDTH-1:0] residual_ext;
    logic              in_fire;
    logic              out_fire;

    prio_find #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_find (
        .vec   (residual_q),
        .idx   (find_idx),
        .found (find_found)
    );

    assign residual_ext = MAX_WIDTH'(residual_q);
    assign bit_mask     = WIDTH'(1) << find_idx;

    assign out_valid = (state_q == SCAN);
    assign out_none  = out_valid && none_q;
    assign out_last  = out_valid && (none_q || is_one_hot(residual_ext));
    assign out_index = (out_valid && !none_q && find_found) ? find_idx : IDX_W'(NONE_INDEX);
    assign dbg_state = state_q;

    // rst is folded in so no capture is advertised while reset is held.
    assign in_ready = !rst && ((state_q == IDLE) || (out_valid && out_ready && out_last));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        none_d     = none_q;
        if (out_fire) begin
            residual_d = residual_q & ~bit_mask;
            if (out_last) begin
                state_d = IDLE;
            end
        end
        // A capture on the retiring beat overrides the return to IDLE.
        if (in_fire) begin
            residual_d = in_data;
            none_d     = (in_data == '0);
            state_d    = SCAN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            residual_q <= '0;
            none_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            none_q     <= none_d;
        end
    end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed bench for priority_scan_encoder: a 16-bit MSB-first instance and
// an 8-bit LSB-first instance; inputs change and outputs are sampled at negedge.
module tb_priority_scan_encoder;
    import priority_scan_pkg::*;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        out_none;
    logic        out_last;
    state_t      dbg_state;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic        out_valid8;
    logic        out_ready8;
    logic [2:0]  out_index8;
    logic        out_none8;
    logic        out_last8;
    state_t      dbg_state8;

    int checks = 0;
    int errors = 0;

    priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_none  (out_none),
        .out_last  (out_last),
        .dbg_state (dbg_state)
    );

    priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_index (out_index8),
        .out_none  (out_none8),
        .out_last  (out_last8),
        .dbg_state (dbg_state8)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: set the 16-bit instance's inputs for the coming rising edge.
    task automatic drive(input logic v, input logic [15:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic test_reset();
        // Outputs while reset is held.
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_index, out_none, out_last, in_ready} !== 8'b0) begin
            errors++;
            $display("FAIL reset_held: got v=%b idx=%0d none=%b last=%b rdy=%b, expected all 0",
                     out_valid, out_index, out_none, out_last, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b state=%0d, expected 1/IDLE", in_ready, dbg_state);
        end
        // Start 0x00FF, take two beats, then reset asynchronously.
        drive(1'b1, 16'h00FF, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b1);
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL reset_beat0: got v=%b idx=%0d last=%b, expected 1/7/0", out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd6, 1'b0}) begin
            errors++;
            $display("FAIL reset_beat1: got v=%b idx=%0d last=%b, expected 1/6/0", out_valid, out_index, out_last);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got out_valid=%b in_ready=%b, expected 0/0", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_stale: cycle %0d got out_valid=%b, expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_none();
        drive(1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h1234, 1'b1);
        checks++;
        if ({out_valid, out_index, out_none, out_last} !== {1'b1, 4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL none_beat: got v=%b idx=%0d none=%b last=%b, expected 1/0/1/1",
                     out_valid, out_index, out_none, out_last);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL none_after: got out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_two_bits();
        drive(1'b1, 16'h8001, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b1);
        checks++;
        if ({out_valid, out_index, out_none, out_last} !== {1'b1, 4'd15, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL two_bits_beat0: got v=%b idx=%0d none=%b last=%b, expected 1/15/0/0",
                     out_valid, out_index, out_none, out_last);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_index, out_none, out_last} !== {1'b1, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL two_bits_beat1: got v=%b idx=%0d none=%b last=%b, expected 1/0/0/1",
                     out_valid, out_index, out_none, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL two_bits_done: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 16'h0404, 1'b0);
        @(negedge clk);
        // A vector offered mid-scan must not be taken.
        drive(1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, out_index, out_last, in_ready} !== {1'b1, 4'd10, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_stall%0d: got v=%b idx=%0d last=%b rdy=%b, expected 1/10/0/0",
                         i, out_valid, out_index, out_last, in_ready);
            end
            @(negedge clk);
        end
        drive(1'b0, 16'hFFFF, 1'b1);
        #1;
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd10, 1'b0}) begin
            errors++;
            $display("FAIL bp_release: got v=%b idx=%0d last=%b, expected 1/10/0", out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL bp_last: got v=%b idx=%0d last=%b, expected 1/2/1", out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h0010, 1'b1);
        @(negedge clk);
        drive(1'b1, 16'h0003, 1'b1);
        #1;
        checks++;
        if ({out_valid, out_index, out_last, in_ready} !== {1'b1, 4'd4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_beat0: got v=%b idx=%0d last=%b rdy=%b, expected 1/4/1/1",
                     out_valid, out_index, out_last, in_ready);
        end
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b1);
        #1;
        checks++;
        if ({out_valid, out_index, out_last, in_ready} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_beat1: got v=%b idx=%0d last=%b rdy=%b, expected 1/1/0/0",
                     out_valid, out_index, out_last, in_ready);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_index, out_last} !== {1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_beat2: got v=%b idx=%0d last=%b, expected 1/0/1", out_valid, out_index, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_lsb_first();
        in_valid8  = 1'b1;
        in_data8   = 8'hA0;
        out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        checks++;
        if ({out_valid8, out_index8, out_none8, out_last8} !== {1'b1, 3'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lsb_beat0: got v=%b idx=%0d none=%b last=%b, expected 1/5/0/0",
                     out_valid8, out_index8, out_none8, out_last8);
        end
        @(negedge clk);
        checks++;
        if ({out_valid8, out_index8, out_none8, out_last8} !== {1'b1, 3'd7, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL lsb_beat1: got v=%b idx=%0d none=%b last=%b, expected 1/7/0/1",
                     out_valid8, out_index8, out_none8, out_last8);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL lsb_done: got out_valid=%b in_ready=%b, expected 0/1", out_valid8, in_ready8);
        end
    endtask

    initial begin
        rst        = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        in_valid8  = 1'b0;
        in_data8   = 8'h00;
        out_ready8 = 1'b0;

        test_reset();
        test_none();
        test_two_bits();
        test_backpressure();
        test_back_to_back();
        test_lsb_first();

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_scan_encoder.md
# priority_scan_encoder

Parametrised, sequential successor to the team's fixed 16-bit priority encoder. It captures a WIDTH-bit request vector through a valid/ready handshake. It then streams out the index of every set bit in priority order, one per accepted output beat, and flags the final beat. An all-zero vector produces a single explicit "none" beat. It sits between request-vector producers (pin-sampled or internal) and any consumer that services requests one index at a time.

## Interface
- WIDTH, 16: request vector width; legal range 2..256.
- IDX_W, $clog2(WIDTH): index width; derived, never overridden.
- MSB_FIRST, 1: 1 = highest set bit reported first; 0 = lowest set bit first.

- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can capture a vector this cycle.
- in_data  in  WIDTH  request vector.
- out_valid  out  1  out_index/out_none/out_last valid.
- out_ready  in  1  consumer accepts current beat.
- out_index  out  IDX_W  index of the current highest-priority remaining bit; 0 when out_none=1.
- out_none  out  1  captured vector was all zeros.
- out_last  out  1  current beat is the final beat for this vector.

## Operation
- Registers: state (IDLE, SCAN), residual[WIDTH], none_flag.
- Input handshake occurs when in_valid && in_ready.
  - Capture loads residual <= in_data and none_flag <= (in_data == 0), and sets state <= SCAN.
- IDLE: in_ready=1, out_valid=0.
- SCAN: out_valid=1.
  - out_index = find-first-set(residual) per MSB_FIRST.
  - out_none = none_flag.
  - out_last = none_flag || (residual has exactly one bit set).
- Output handshake occurs when out_valid && out_ready.
  - The reported bit is cleared in residual.
  - If out_last, the vector is retired: state <= IDLE, unless a new vector is captured in the same cycle.
- Back-to-back: in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - A capture coinciding with the last-beat handshake loads the new vector and stays in SCAN with no bubble.
  - This is the only combinational path from input to output (out_ready to in_ready).
- in_data is ignored except on capture. Changes to in_data during SCAN have no effect.
- Outputs are functions of registers only, except in_ready as stated above.

## Timing
- Reset (rst high, asynchronous) forces state=IDLE, residual=0, none_flag=0.
  - While rst is high: out_valid=0, out_index=0, out_none=0, out_last=0, in_ready=0.
  - In the first cycle after rst falls, in_ready=1.
- Reset mid-scan discards the vector. No further beats are emitted for it.
- Latency: a capture at edge N gives out_valid=1 in the cycle following edge N.
- Throughput: one index per cycle while out_ready=1. A vector with k set bits occupies k beats (1 beat if k=0).
- Backpressure: while out_valid && !out_ready, all outputs hold stable.
- out_valid never drops without a completed handshake, except on reset.

## Structure
- Package priority_scan_pkg holds:
  - the state enum (IDLE, SCAN);
  - the out_none index constant (0);
  - a popcount-is-one helper function.
- Sub-module prio_find: purely combinational find-first-set.
  - Parameters: WIDTH, MSB_FIRST.
  - Ports: vec[WIDTH] in, idx[IDX_W] out, found out.
  - The top instantiates it once on residual.

## Test plan
- Reset: start a scan of 0x00FF, assert rst asynchronously after 2 beats -> out_valid=0 immediately. After release: in_ready=1 and no stale beats.
- WIDTH=16, in_data=0x0000 -> exactly one beat: out_none=1, out_index=0, out_last=1. Then in_ready=1.
- WIDTH=16, MSB_FIRST=1, in_data=0x8001, out_ready=1 -> beats index 15 (last=0), then index 0 (last=1). out_valid on the cycle after capture.
- Backpressure: in_data=0x0404, hold out_ready=0 for 3 cycles -> out_index=10 stable with out_valid=1. Then 10, then 2 (last=1).
- Back-to-back: 0x0010 followed by 0x0003, with in_valid held high -> second capture on the index-4 last beat. Indices 4, 1, 0 appear on consecutive cycles with no bubble.
- WIDTH=8, MSB_FIRST=0, in_data=0xA0 -> beats 5 (last=0), then 7 (last=1).
